// File: rtl/csr_file_if.sv
// csr_file_if: decoder/core <-> CSR file signal bundle.
//   master : the core side. It drives the decode strobes, the operands and the trap/mret events.
//            It receives the read data, the illegal flag and the trap-control outputs.
//   slave  : the CSR file itself, which is the mirror image of master.
// Signals:
//   is_csr, csr_read_en, csr_write_en : SYSTEM decode and read/write request strobes
//   funct3, csr_addr, rs1_field, rs1_data : instruction fields and the rs1 operand
//   instr_retire, trap_valid, trap_pc, trap_cause, mret_valid : retire and trap bookkeeping
//   csr_rdata, csr_illegal, mtvec_out, mepc_out, mie_out : responses
interface csr_file_if;
    logic        is_csr;
    logic        csr_read_en;
    logic        csr_write_en;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_field;
    logic [31:0] rs1_data;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_valid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    modport master (
        output is_csr, csr_read_en, csr_write_en, funct3, csr_addr, rs1_field, rs1_data,
               instr_retire, trap_valid, trap_pc, trap_cause, mret_valid,
        input  csr_rdata, csr_illegal, mtvec_out, mepc_out, mie_out
    );

    modport slave (
        input  is_csr, csr_read_en, csr_write_en, funct3, csr_addr, rs1_field, rs1_data,
               instr_retire, trap_valid, trap_pc, trap_cause, mret_valid,
        output csr_rdata, csr_illegal, mtvec_out, mepc_out, mie_out
    );
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for a single-cycle RV32IM core.
//   The read is combinational and returns the old value for rd.
//   RW/RS/RC updates (register and immediate forms) take effect at the clock edge.
//   64-bit mcycle/minstret counters run here, along with trap/mret bookkeeping of
//   mstatus.MIE/MPIE, mepc and mcause.
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset
//   bus  : csr_file_if.slave (decode strobes, operands, trap/mret events, responses)
module csr_file #(
    parameter logic [31:0] MISA_VALUE = 32'h4000_1100,
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter bit          COUNTER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    csr_file_if.slave   bus
);

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_old;
    logic        w_mapped;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_wr_req;
    logic        w_illegal;
    logic        w_wr;

    // Read mux, which gives the raw current value of the addressed CSR.
    always_comb begin
        w_old    = 32'd0;
        w_mapped = 1'b1;
        case (bus.csr_addr)
            12'h300: w_old = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
            12'h301: w_old = MISA_VALUE;
            12'h305: w_old = r_mtvec;
            12'h340: w_old = r_mscratch;
            12'h341: w_old = r_mepc;
            12'h342: w_old = r_mcause;
            12'hB00, 12'hC00: w_old = r_mcycle[31:0];
            12'hB80, 12'hC80: w_old = r_mcycle[63:32];
            12'hB02, 12'hC02: w_old = r_minstret[31:0];
            12'hB82, 12'hC82: w_old = r_minstret[63:32];
            12'hF14: w_old = HART_ID;
            default: w_mapped = 1'b0;
        endcase
    end

    // In the immediate forms (funct3[2] set), rs1_field is a zero-extended zimm.
    assign w_src = bus.funct3[2] ? {27'd0, bus.rs1_field} : bus.rs1_data;

    always_comb begin
        case (bus.funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    // Set and clear with rs1 = x0 (or zimm = 0) are pure reads.
    // They therefore never write and never fault on read-only CSRs.
    assign w_wr_req  = bus.is_csr & bus.csr_write_en & (bus.funct3 != 3'b000) &
                       ~(bus.funct3[1] & (bus.rs1_field == 5'd0));
    assign w_illegal = bus.is_csr & (bus.funct3 != 3'b000) &
                       (~w_mapped | (w_wr_req & (bus.csr_addr[11:10] == 2'b11)));
    assign w_wr      = w_wr_req & ~w_illegal;

    assign bus.csr_rdata   = (bus.is_csr & bus.csr_read_en & w_mapped) ? w_old : 32'd0;
    assign bus.csr_illegal = w_illegal;
    assign bus.mtvec_out   = r_mtvec;
    assign bus.mepc_out    = r_mepc;
    assign bus.mie_out     = r_mie;

    // A trap outranks mret, and mret outranks a CSR write to the same field.
    // Writes to CSRs that a trap does not touch still land in the same cycle.
    // A misa write falls through every branch here, so it is silently ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= 32'd0;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
        end else begin
            if (bus.trap_valid) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (bus.mret_valid) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr && bus.csr_addr == 12'h300) begin
                r_mie  <= w_new[3];
                r_mpie <= w_new[7];
            end

            if (bus.trap_valid) begin
                r_mepc   <= {bus.trap_pc[31:2], 2'b00};
                r_mcause <= bus.trap_cause;
            end else begin
                if (w_wr && bus.csr_addr == 12'h341) r_mepc   <= {w_new[31:2], 2'b00};
                if (w_wr && bus.csr_addr == 12'h342) r_mcause <= w_new;
            end

            if (w_wr && bus.csr_addr == 12'h305) r_mtvec    <= {w_new[31:2], 2'b00};
            if (w_wr && bus.csr_addr == 12'h340) r_mscratch <= w_new;
        end
    end

    // When a counter half is written, it takes the new value and the other half holds.
    // The whole 64-bit counter skips its increment in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_wr && bus.csr_addr == 12'hB00)      r_mcycle[31:0]  <= w_new;
            else if (w_wr && bus.csr_addr == 12'hB80) r_mcycle[63:32] <= w_new;
            else if (COUNTER_EN)                      r_mcycle        <= r_mcycle + 64'd1;

            if (w_wr && bus.csr_addr == 12'hB02)      r_minstret[31:0]  <= w_new;
            else if (w_wr && bus.csr_addr == 12'hB82) r_minstret[63:32] <= w_new;
            else if (COUNTER_EN && bus.instr_retire)  r_minstret        <= r_minstret + 64'd1;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file.
//   Each feature has its own task with its own inline comparisons.
//   Inputs change just after the falling edge, and outputs are sampled 1 ns later.
module tb_csr_file;
    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    logic [63:0] tb_cyc;  // clock edges since reset release; valid until mcycle is written

    csr_file_if bus();

    csr_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 64'd0;
        else     tb_cyc <= tb_cyc + 64'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.is_csr       = 1'b0;
        bus.csr_read_en  = 1'b0;
        bus.csr_write_en = 1'b0;
        bus.funct3       = 3'b000;
        bus.csr_addr     = 12'h000;
        bus.rs1_field    = 5'd0;
        bus.rs1_data     = 32'd0;
        bus.instr_retire = 1'b0;
        bus.trap_valid   = 1'b0;
        bus.trap_pc      = 32'd0;
        bus.trap_cause   = 32'd0;
        bus.mret_valid   = 1'b0;
    endtask

    task automatic drv(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] z,
                       input logic [31:0] d, input logic rd, input logic wr);
        bus.is_csr       = 1'b1;
        bus.csr_read_en  = rd;
        bus.csr_write_en = wr;
        bus.funct3       = f3;
        bus.csr_addr     = a;
        bus.rs1_field    = z;
        bus.rs1_data     = d;
    endtask

    // CSRRS with x0: a pure read.
    task automatic rd(input logic [11:0] a);
        drv(3'b010, a, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        n_run++; if (bus.mtvec_out !== 32'd0) begin n_fail++; $display("FAIL rst_mtvec: got %h want %h", bus.mtvec_out, 32'd0); end
        n_run++; if (bus.mepc_out !== 32'd0) begin n_fail++; $display("FAIL rst_mepc: got %h want %h", bus.mepc_out, 32'd0); end
        n_run++; if (bus.mie_out !== 1'b0) begin n_fail++; $display("FAIL rst_mie: got %b want 0", bus.mie_out); end
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_mcycle: got %h want %h", bus.csr_rdata, 32'd0); end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'd10) begin n_fail++; $display("FAIL cnt_lo10: got %h want %h", bus.csr_rdata, 32'd10); end
        n_run++; if (bus.csr_illegal !== 1'b0) begin n_fail++; $display("FAIL cnt_legal: got %b want 0", bus.csr_illegal); end
        rd(12'hB80);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL cnt_hi0: got %h want %h", bus.csr_rdata, 32'd0); end
        rd(12'hC00);
        n_run++; if (bus.csr_rdata !== 32'd10) begin n_fail++; $display("FAIL cycle_shadow: got %h want %h", bus.csr_rdata, 32'd10); end
    endtask

    task automatic test_rw_scratch();
        drv(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        #1;
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL rw_old: got %h want %h", bus.csr_rdata, 32'd0); end
        tick();
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_new: got %h want %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        drv(3'b111, 12'h340, 5'hF, 32'd0, 1'b1, 1'b1);
        #1;
        n_run++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rci_old: got %h want %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        tick();
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'hDEAD_BEE0) begin n_fail++; $display("FAIL rci_new: got %h want %h", bus.csr_rdata, 32'hDEAD_BEE0); end
        // RS with rs1=x0 must not write, even with nonzero rs1_data
        drv(3'b010, 12'h340, 5'd0, 32'hFFFF_0000, 1'b1, 1'b1);
        tick();
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'hDEAD_BEE0) begin n_fail++; $display("FAIL rs_x0: got %h want %h", bus.csr_rdata, 32'hDEAD_BEE0); end
        drv(3'b010, 12'h340, 5'd3, 32'h0000_000F, 1'b1, 1'b1);
        tick();
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rs_set: got %h want %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        drv(3'b010, 12'h340, 5'd0, 32'd0, 1'b0, 1'b0);
        #1;
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL rd_gate: got %h want %h", bus.csr_rdata, 32'd0); end
    endtask

    task automatic test_misc_csrs();
        drv(3'b001, 12'h305, 5'd1, 32'h8000_0007, 1'b0, 1'b1);
        tick();
        n_run++; if (bus.mtvec_out !== 32'h8000_0004) begin n_fail++; $display("FAIL mtvec_align: got %h want %h", bus.mtvec_out, 32'h8000_0004); end
        rd(12'h301);
        n_run++; if (bus.csr_rdata !== 32'h4000_1100) begin n_fail++; $display("FAIL misa: got %h want %h", bus.csr_rdata, 32'h4000_1100); end
        drv(3'b001, 12'h301, 5'd1, 32'h0, 1'b1, 1'b1);
        #1;
        n_run++; if (bus.csr_illegal !== 1'b0) begin n_fail++; $display("FAIL misa_wr_legal: got %b want 0", bus.csr_illegal); end
        tick();
        rd(12'h301);
        n_run++; if (bus.csr_rdata !== 32'h4000_1100) begin n_fail++; $display("FAIL misa_hold: got %h want %h", bus.csr_rdata, 32'h4000_1100); end
        rd(12'hF14);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mhartid: got %h want %h", bus.csr_rdata, 32'd0); end
        drv(3'b110, 12'hF14, 5'd1, 32'd0, 1'b1, 1'b1);
        #1;
        n_run++; if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL mhartid_wr: got %b want 1", bus.csr_illegal); end
    endtask

    task automatic test_ro();
        rd(12'hC00);
        n_run++; if (bus.csr_illegal !== 1'b0) begin n_fail++; $display("FAIL c00_rs_legal: got %b want 0", bus.csr_illegal); end
        n_run++; if (bus.csr_rdata !== tb_cyc[31:0]) begin n_fail++; $display("FAIL c00_val: got %h want %h", bus.csr_rdata, tb_cyc[31:0]); end
        drv(3'b001, 12'hC00, 5'd1, 32'h0000_1234, 1'b1, 1'b1);
        #1;
        n_run++; if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL c00_rw_illegal: got %b want 1", bus.csr_illegal); end
        tick();
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== tb_cyc[31:0]) begin n_fail++; $display("FAIL c00_nochange: got %h want %h", bus.csr_rdata, tb_cyc[31:0]); end
        rd(12'h7C0);
        n_run++; if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL unmapped_illegal: got %b want 1", bus.csr_illegal); end
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_rdata: got %h want %h", bus.csr_rdata, 32'd0); end
    endtask

    task automatic test_counters();
        drv(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        drv(3'b001, 12'hB80, 5'd1, 32'h0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL carry_lo: got %h want %h", bus.csr_rdata, 32'd0); end
        rd(12'hB80);
        n_run++; if (bus.csr_rdata !== 32'd1) begin n_fail++; $display("FAIL carry_hi: got %h want %h", bus.csr_rdata, 32'd1); end
        rd(12'hC80);
        n_run++; if (bus.csr_rdata !== 32'd1) begin n_fail++; $display("FAIL carry_c80: got %h want %h", bus.csr_rdata, 32'd1); end
        drv(3'b001, 12'hB02, 5'd1, 32'h1234_5678, 1'b0, 1'b1);
        bus.instr_retire = 1'b1;
        tick();
        bus.instr_retire = 1'b0;
        rd(12'hB02);
        n_run++; if (bus.csr_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL instret_wr: got %h want %h", bus.csr_rdata, 32'h1234_5678); end
        idle();
        bus.instr_retire = 1'b1;
        repeat (3) tick();
        bus.instr_retire = 1'b0;
        tick();
        rd(12'hC02);
        n_run++; if (bus.csr_rdata !== 32'h1234_567B) begin n_fail++; $display("FAIL instret_cnt: got %h want %h", bus.csr_rdata, 32'h1234_567B); end
        rd(12'hB82);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL instret_hi: got %h want %h", bus.csr_rdata, 32'd0); end
        drv(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        drv(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL max_lo: got %h want %h", bus.csr_rdata, 32'hFFFF_FFFF); end
        idle();
        tick();
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL wrap_lo: got %h want %h", bus.csr_rdata, 32'd0); end
        rd(12'hB80);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL wrap_hi: got %h want %h", bus.csr_rdata, 32'd0); end
    endtask

    task automatic test_trap();
        idle();
        drv(3'b110, 12'h300, 5'd8, 32'd0, 1'b0, 1'b1);
        tick();
        n_run++; if (bus.mie_out !== 1'b1) begin n_fail++; $display("FAIL mie_set: got %b want 1", bus.mie_out); end
        idle();
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h0000_0106;
        bus.trap_cause = 32'h0000_000B;
        tick();
        idle();
        n_run++; if (bus.mepc_out !== 32'h0000_0104) begin n_fail++; $display("FAIL trap_mepc: got %h want %h", bus.mepc_out, 32'h104); end
        n_run++; if (bus.mie_out !== 1'b0) begin n_fail++; $display("FAIL trap_mie: got %b want 0", bus.mie_out); end
        rd(12'h342);
        n_run++; if (bus.csr_rdata !== 32'h0000_000B) begin n_fail++; $display("FAIL trap_mcause: got %h want %h", bus.csr_rdata, 32'hB); end
        rd(12'h300);
        n_run++; if (bus.csr_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL trap_mstatus: got %h want %h", bus.csr_rdata, 32'h80); end
        idle();
        bus.mret_valid = 1'b1;
        tick();
        idle();
        n_run++; if (bus.mie_out !== 1'b1) begin n_fail++; $display("FAIL mret_mie: got %b want 1", bus.mie_out); end
        rd(12'h300);
        n_run++; if (bus.csr_rdata !== 32'h0000_0088) begin n_fail++; $display("FAIL mret_mstatus: got %h want %h", bus.csr_rdata, 32'h88); end
        drv(3'b001, 12'h341, 5'd1, 32'h0000_0200, 1'b0, 1'b1);
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h0000_0300;
        bus.trap_cause = 32'h0000_0007;
        tick();
        idle();
        n_run++; if (bus.mepc_out !== 32'h0000_0300) begin n_fail++; $display("FAIL trap_vs_wr: got %h want %h", bus.mepc_out, 32'h300); end
        drv(3'b001, 12'h340, 5'd1, 32'h0000_0077, 1'b0, 1'b1);
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h0000_0400;
        tick();
        idle();
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL trap_other_wr: got %h want %h", bus.csr_rdata, 32'h77); end
        n_run++; if (bus.mepc_out !== 32'h0000_0400) begin n_fail++; $display("FAIL trap2_mepc: got %h want %h", bus.mepc_out, 32'h400); end
        // MPIE=0 here; mret must win over the concurrent MIE set
        drv(3'b110, 12'h300, 5'd8, 32'd0, 1'b0, 1'b1);
        bus.mret_valid = 1'b1;
        tick();
        idle();
        rd(12'h300);
        n_run++; if (bus.csr_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL mret_vs_wr: got %h want %h", bus.csr_rdata, 32'h80); end
    endtask

    task automatic test_reset_mid();
        drv(3'b110, 12'h300, 5'd8, 32'd0, 1'b0, 1'b1);
        tick();
        drv(3'b001, 12'h340, 5'd1, 32'h0000_0055, 1'b0, 1'b1);
        tick();
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL pre_rst_scratch: got %h want %h", bus.csr_rdata, 32'h55); end
        n_run++; if (bus.mie_out !== 1'b1) begin n_fail++; $display("FAIL pre_rst_mie: got %b want 1", bus.mie_out); end
        drv(3'b001, 12'h340, 5'd1, 32'h0000_00AA, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rst_scratch: got %h want %h", bus.csr_rdata, 32'd0); end
        n_run++; if (bus.mie_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mie: got %b want 0", bus.mie_out); end
        n_run++; if (bus.mepc_out !== 32'd0) begin n_fail++; $display("FAIL mid_rst_mepc: got %h want %h", bus.mepc_out, 32'd0); end
        n_run++; if (bus.mtvec_out !== 32'd0) begin n_fail++; $display("FAIL mid_rst_mtvec: got %h want %h", bus.mtvec_out, 32'd0); end
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rst_mcycle: got %h want %h", bus.csr_rdata, 32'd0); end
        rd(12'hB02);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rst_minstret: got %h want %h", bus.csr_rdata, 32'd0); end
        tick();
        rst = 1'b0;
        idle();
        tick();
        rd(12'hB00);
        n_run++; if (bus.csr_rdata !== 32'd1) begin n_fail++; $display("FAIL first_count: got %h want %h", bus.csr_rdata, 32'd1); end
        rd(12'h340);
        n_run++; if (bus.csr_rdata !== 32'd0) begin n_fail++; $display("FAIL post_rst_scratch: got %h want %h", bus.csr_rdata, 32'd0); end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_rw_scratch();
        test_misc_csrs();
        test_ro();
        test_counters();
        test_trap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
